// File: rtl/digit_scan_ctrl_if.sv
// Signal bundle between the scan controller and its driver/consumer.
// The master side drives the enables and mask; the slave (the controller) drives the scan outputs.
interface digit_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
) ();
    localparam int unsigned SEL_W = $clog2(NUM_DIGITS);

    logic                  i_en;
    logic                  i_sync;
    logic [NUM_DIGITS-1:0] i_blank_mask;
    logic [SEL_W-1:0]      o_sel;
    logic [NUM_DIGITS-1:0] o_an;
    logic                  o_tick;
    logic                  o_frame;

    modport master (
        output i_en, i_sync, i_blank_mask,
        input  o_sel, o_an, o_tick, o_frame
    );

    modport slave (
        input  i_en, i_sync, i_blank_mask,
        output o_sel, o_an, o_tick, o_frame
    );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Multiplexed-display scan controller: a prescaler steps a digit index round-robin and drives
// active-low one-hot digit enables with blanking, optional blank skipping and restart.
module digit_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIV        = 257,
    parameter int unsigned SKIP_BLANK = 0
) (
    input logic              clk,
    input logic              rst_n,
    digit_scan_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned SEL_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0]      sel_q, sel_d, sel_nxt;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  tick_q, tick_d;
    logic                  frame_q, frame_d;

    // Circular search from sel_q+1; landing back on sel_q covers the lone-unmasked case.
    always_comb begin : next_index
        logic [SEL_W-1:0] cand;
        logic             found;
        cand    = sel_q;
        found   = 1'b0;
        sel_nxt = sel_q;
        if (SKIP_BLANK == 0) begin
            sel_nxt = (sel_q == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel_q + 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                cand = (cand == SEL_W'(NUM_DIGITS - 1)) ? '0 : cand + 1'b1;
                if (!found && !bus.i_blank_mask[cand]) begin
                    sel_nxt = cand;
                    found   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        tick_d  = 1'b0;
        frame_d = 1'b0;
        if (bus.i_sync) begin
            cnt_d = '0;
            sel_d = '0;
        end else if (bus.i_en) begin
            if (cnt_q == CNT_W'(DIV - 1)) begin
                cnt_d   = '0;
                sel_d   = sel_nxt;
                tick_d  = 1'b1;
                frame_d = (sel_nxt <= sel_q);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Enables follow the index being loaded this edge, not the one being left.
        an_d = (bus.i_en && !bus.i_blank_mask[sel_d]) ? ~(NUM_DIGITS'(1) << sel_d) : '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            sel_q   <= '0;
            an_q    <= '1;
            tick_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

    assign bus.o_sel   = sel_q;
    assign bus.o_an    = an_q;
    assign bus.o_tick  = tick_q;
    assign bus.o_frame = frame_q;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: two instances (no skip / skip blanked) share stimulus; expected
// outputs per cycle are queued by the stimulus and checked by per-instance monitors.
module tb_digit_scan_ctrl;
    typedef struct {
        int         c;
        logic [1:0] sel;
        logic [3:0] an;
        logic       tick;
        logic       frame;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q0[$];
    exp_t q1[$];

    digit_scan_ctrl_if #(.NUM_DIGITS(4)) bus0 ();
    digit_scan_ctrl_if #(.NUM_DIGITS(4)) bus1 ();

    digit_scan_ctrl #(.NUM_DIGITS(4), .DIV(4), .SKIP_BLANK(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    digit_scan_ctrl #(.NUM_DIGITS(4), .DIV(4), .SKIP_BLANK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input int id, input exp_t e, input logic [1:0] sel, input logic [3:0] an,
                       input logic tick, input logic frame);
        vectors++;
        if ({sel, an, tick, frame} !== {e.sel, e.an, e.tick, e.frame}) begin
            miscompares++;
            $display("FAIL dut%0d cyc %0d: got sel=%0d an=%b tick=%b frame=%b, want sel=%0d an=%b tick=%b frame=%b",
                     id, cyc, sel, an, tick, frame, e.sel, e.an, e.tick, e.frame);
        end
    endtask

    // id 2 pushes to both instances
    task automatic push(input int id, input int c, input logic [1:0] s, input logic [3:0] a,
                        input logic t, input logic f);
        exp_t e;
        e = '{c, s, a, t, f};
        if (id != 1) q0.push_back(e);
        if (id != 0) q1.push_back(e);
    endtask

    task automatic drive(input logic en, input logic sync, input logic [3:0] mask);
        bus0.i_en = en; bus0.i_sync = sync; bus0.i_blank_mask = mask;
        bus1.i_en = en; bus1.i_sync = sync; bus1.i_blank_mask = mask;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (q0.size() != 0 && q0[0].c == cyc) begin
            cmp(0, q0[0], bus0.o_sel, bus0.o_an, bus0.o_tick, bus0.o_frame);
            void'(q0.pop_front());
        end else if (bus0.o_tick) begin
            vectors++; miscompares++;
            $display("FAIL dut0 unexpected tick at cyc %0d: got sel=%0d, want no tick", cyc, bus0.o_sel);
        end
    end

    always @(negedge clk) begin
        if (q1.size() != 0 && q1[0].c == cyc) begin
            cmp(1, q1[0], bus1.o_sel, bus1.o_an, bus1.o_tick, bus1.o_frame);
            void'(q1.pop_front());
        end else if (bus1.o_tick) begin
            vectors++; miscompares++;
            $display("FAIL dut1 unexpected tick at cyc %0d: got sel=%0d, want no tick", cyc, bus1.o_sel);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   b;
        exp_t rst_e;
        rst_e = '{0, 2'd0, 4'b1111, 1'b0, 1'b0};
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'b0000);
        repeat (2) @(negedge clk);
        #1;
        cmp(0, rst_e, bus0.o_sel, bus0.o_an, bus0.o_tick, bus0.o_frame);
        cmp(1, rst_e, bus1.o_sel, bus1.o_an, bus1.o_tick, bus1.o_frame);

        // Plain scan from reset
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 4'b0000);
        b = cyc;
        push(2, b + 1, 2'd0, 4'b1110, 1'b0, 1'b0);
        push(2, b + 4, 2'd1, 4'b1101, 1'b1, 1'b0);
        push(2, b + 8, 2'd2, 4'b1011, 1'b1, 1'b0);
        push(2, b + 12, 2'd3, 4'b0111, 1'b1, 1'b0);
        push(2, b + 16, 2'd0, 4'b1110, 1'b1, 1'b1);
        wait_to(b + 16);

        // Digit 2 blanked: dark slot on dut0, skipped on dut1
        b = cyc;
        drive(1'b1, 1'b0, 4'b0100);
        push(0, b + 4, 2'd1, 4'b1101, 1'b1, 1'b0);
        push(0, b + 8, 2'd2, 4'b1111, 1'b1, 1'b0);
        push(0, b + 9, 2'd2, 4'b1111, 1'b0, 1'b0);
        push(0, b + 12, 2'd3, 4'b0111, 1'b1, 1'b0);
        push(0, b + 16, 2'd0, 4'b1110, 1'b1, 1'b1);
        push(0, b + 20, 2'd1, 4'b1101, 1'b1, 1'b0);
        push(0, b + 24, 2'd2, 4'b1111, 1'b1, 1'b0);
        push(1, b + 4, 2'd1, 4'b1101, 1'b1, 1'b0);
        push(1, b + 8, 2'd3, 4'b0111, 1'b1, 1'b0);
        push(1, b + 12, 2'd0, 4'b1110, 1'b1, 1'b1);
        push(1, b + 16, 2'd1, 4'b1101, 1'b1, 1'b0);
        push(1, b + 20, 2'd3, 4'b0111, 1'b1, 1'b0);
        push(1, b + 24, 2'd0, 4'b1110, 1'b1, 1'b1);
        wait_to(b + 24);

        // All digits blanked, restarted by sync
        b = cyc;
        drive(1'b1, 1'b1, 4'b1111);
        push(2, b + 1, 2'd0, 4'b1111, 1'b0, 1'b0);
        push(0, b + 5, 2'd1, 4'b1111, 1'b1, 1'b0);
        push(0, b + 9, 2'd2, 4'b1111, 1'b1, 1'b0);
        push(0, b + 13, 2'd3, 4'b1111, 1'b1, 1'b0);
        push(1, b + 5, 2'd0, 4'b1111, 1'b1, 1'b1);
        push(1, b + 9, 2'd0, 4'b1111, 1'b1, 1'b1);
        push(1, b + 13, 2'd0, 4'b1111, 1'b1, 1'b1);
        wait_to(b + 1);
        drive(1'b1, 1'b0, 4'b1111);
        wait_to(b + 13);

        // Enable drop at cnt=2, sync at sel=3/cnt=3, then async reset mid-slot
        b = cyc;
        drive(1'b1, 1'b1, 4'b0000);
        push(2, b + 1, 2'd0, 4'b1110, 1'b0, 1'b0);
        push(2, b + 4, 2'd0, 4'b1111, 1'b0, 1'b0);
        push(2, b + 8, 2'd0, 4'b1111, 1'b0, 1'b0);
        push(2, b + 9, 2'd0, 4'b1110, 1'b0, 1'b0);
        push(2, b + 10, 2'd1, 4'b1101, 1'b1, 1'b0);
        push(2, b + 14, 2'd2, 4'b1011, 1'b1, 1'b0);
        push(2, b + 18, 2'd3, 4'b0111, 1'b1, 1'b0);
        push(2, b + 21, 2'd3, 4'b0111, 1'b0, 1'b0);
        push(2, b + 22, 2'd0, 4'b1110, 1'b0, 1'b0);
        push(2, b + 26, 2'd1, 4'b1101, 1'b1, 1'b0);
        wait_to(b + 1);
        drive(1'b1, 1'b0, 4'b0000);
        wait_to(b + 3);
        drive(1'b0, 1'b0, 4'b0000);
        wait_to(b + 8);
        drive(1'b1, 1'b0, 4'b0000);
        wait_to(b + 21);
        drive(1'b1, 1'b1, 4'b0000);
        wait_to(b + 22);
        drive(1'b1, 1'b0, 4'b0000);
        wait_to(b + 26);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        cmp(0, rst_e, bus0.o_sel, bus0.o_an, bus0.o_tick, bus0.o_frame);
        cmp(1, rst_e, bus1.o_sel, bus1.o_an, bus1.o_tick, bus1.o_frame);

        repeat (2) @(negedge clk);
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL pending checks: got %0d/%0d left, want 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
